// File: rtl/control_lva_stack32_if.sv
// Opcode issue / completion bus between the CPU top level and the bytecode execution core.
interface control_lva_stack32_if;
    logic        op_start;
    logic [7:0]  op_code;
    logic [7:0]  arg1;
    logic [7:0]  arg2;
    logic [15:0] offset;
    logic        op_done;
    logic        busy;
    logic [31:0] stack_top;
    logic [6:0]  stack_depth;
    logic        error;

    modport master (
        output op_start, op_code, arg1, arg2,
        input  offset, op_done, busy, stack_top, stack_depth, error
    );

    modport slave (
        input  op_start, op_code, arg1, arg2,
        output offset, op_done, busy, stack_top, stack_depth, error
    );
endinterface

// File: rtl/control_lva_stack32.sv
// Bali bytecode execution core: control FSM, local variable array and operand stack.
// Executes one integer JVM opcode per op_start and reports the PC increment on op_done.
module control_lva_stack32 #(
    parameter int unsigned LVA_SIZE    = 256,
    parameter int unsigned STACK_DEPTH = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    control_lva_stack32_if.slave bus
);
    localparam int unsigned SAW  = $clog2(STACK_DEPTH);
    localparam int unsigned LAW  = $clog2(LVA_SIZE);
    localparam logic [6:0]  FULL = 7'(STACK_DEPTH);

    typedef enum logic [2:0] {IDLE, DECODE, POP_B, POP_A, LVA_RD, EXEC, WRITE, DONE} state_t;
    typedef enum logic [3:0] {
        C_NOP, C_CONST, C_BIPUSH, C_SIPUSH, C_ILOAD, C_ISTORE, C_POP, C_DUP,
        C_SWAP, C_BIN, C_INEG, C_IINC, C_IF1, C_IF2, C_GOTO, C_ILL
    } opcls_t;

    state_t      state, state_nx;
    opcls_t      cls;
    logic [7:0]  opc_q, arg1_q, arg2_q, lva_idx;
    logic [31:0] a_q, b_q, lva_rd_q, alu_res, push_val, lva_wdata, top_w;
    logic [15:0] inst_len;
    logic [6:0]  depth_q;
    logic        err_q, taken, accept, empty, full;
    logic        pop_en, push_en, push2_en, lva_we, lva_re, err_set;

    logic [31:0] stk [STACK_DEPTH];
    logic [31:0] lva [LVA_SIZE];

    assign empty  = (depth_q == '0);
    assign full   = (depth_q == FULL);
    assign top_w  = empty ? '0 : stk[SAW'(depth_q - 7'd1)];
    assign accept = bus.op_start && ((state == IDLE) || (state == DONE));

    always_comb begin
        cls = C_ILL;
        case (opc_q)
            8'h00:                                           cls = C_NOP;
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: cls = C_CONST;
            8'h10:                                           cls = C_BIPUSH;
            8'h11:                                           cls = C_SIPUSH;
            8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D:               cls = C_ILOAD;
            8'h36, 8'h3B, 8'h3C, 8'h3D, 8'h3E:               cls = C_ISTORE;
            8'h57:                                           cls = C_POP;
            8'h59:                                           cls = C_DUP;
            8'h5F:                                           cls = C_SWAP;
            8'h60, 8'h64, 8'h68, 8'h7E, 8'h80, 8'h82:        cls = C_BIN;
            8'h74:                                           cls = C_INEG;
            8'h84:                                           cls = C_IINC;
            8'h99, 8'h9A:                                    cls = C_IF1;
            8'h9F, 8'hA0, 8'hA1, 8'hA2:                      cls = C_IF2;
            8'hA7:                                           cls = C_GOTO;
            default:                                         cls = C_ILL;
        endcase
    end

    // Short forms (iload_n / istore_n) encode the local index in the opcode.
    always_comb begin
        lva_idx = arg1_q;
        if (opc_q inside {[8'h1A:8'h1D]})      lva_idx = opc_q - 8'h1A;
        else if (opc_q inside {[8'h3B:8'h3E]}) lva_idx = opc_q - 8'h3B;
    end

    always_comb begin
        alu_res = '0;
        case (opc_q)
            8'h60:   alu_res = a_q + b_q;
            8'h64:   alu_res = a_q - b_q;
            8'h68:   alu_res = a_q * b_q;
            8'h7E:   alu_res = a_q & b_q;
            8'h80:   alu_res = a_q | b_q;
            8'h82:   alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
        taken = 1'b0;
        case (opc_q)
            8'h99:   taken = (b_q == '0);
            8'h9A:   taken = (b_q != '0);
            8'h9F:   taken = (a_q == b_q);
            8'hA0:   taken = (a_q != b_q);
            8'hA1:   taken = ($signed(a_q) < $signed(b_q));
            8'hA2:   taken = ($signed(a_q) >= $signed(b_q));
            8'hA7:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        inst_len = 16'd1;
        case (cls)
            C_BIPUSH:             inst_len = 16'd2;
            C_SIPUSH, C_IINC:     inst_len = 16'd3;
            C_IF1, C_IF2:         inst_len = 16'd3;
            C_ILOAD:              inst_len = (opc_q == 8'h15) ? 16'd2 : 16'd1;
            C_ISTORE:             inst_len = (opc_q == 8'h36) ? 16'd2 : 16'd1;
            default:              inst_len = 16'd1;
        endcase
    end

    always_comb begin
        state_nx  = state;
        pop_en    = 1'b0;
        push_en   = 1'b0;
        push2_en  = 1'b0;
        push_val  = '0;
        lva_we    = 1'b0;
        lva_re    = 1'b0;
        lva_wdata = '0;
        err_set   = 1'b0;
        case (state)
            IDLE: if (bus.op_start) state_nx = DECODE;
            DECODE: begin
                case (cls)
                    C_POP, C_ISTORE, C_INEG, C_IF1,
                    C_BIN, C_SWAP, C_IF2:                  state_nx = POP_B;
                    C_ILOAD, C_IINC:                       state_nx = LVA_RD;
                    C_CONST, C_BIPUSH, C_SIPUSH, C_DUP:    state_nx = WRITE;
                    C_ILL: begin
                        err_set  = 1'b1;
                        state_nx = DONE;
                    end
                    default:                               state_nx = DONE;
                endcase
            end
            POP_B: begin
                pop_en = 1'b1;
                case (cls)
                    C_BIN, C_SWAP, C_IF2: state_nx = POP_A;
                    C_INEG:               state_nx = EXEC;
                    C_ISTORE:             state_nx = WRITE;
                    default:              state_nx = DONE;
                endcase
            end
            POP_A: begin
                pop_en   = 1'b1;
                state_nx = (cls == C_IF2) ? DONE : EXEC;
            end
            LVA_RD: begin
                lva_re   = 1'b1;
                state_nx = (cls == C_IINC) ? EXEC : WRITE;
            end
            EXEC: begin
                state_nx = DONE;
                case (cls)
                    C_BIN:  begin push_en = 1'b1; push_val = alu_res;   end
                    C_INEG: begin push_en = 1'b1; push_val = '0 - b_q;  end
                    C_SWAP: push2_en = 1'b1;
                    C_IINC: begin
                        lva_we    = 1'b1;
                        lva_wdata = lva_rd_q + {{24{arg2_q[7]}}, arg2_q};
                    end
                    default: ;
                endcase
            end
            WRITE: begin
                state_nx = DONE;
                case (cls)
                    C_CONST:  begin push_en = 1'b1; push_val = {24'h0, opc_q} - 32'd3;                 end
                    C_BIPUSH: begin push_en = 1'b1; push_val = {{24{arg1_q[7]}}, arg1_q};           end
                    C_SIPUSH: begin push_en = 1'b1; push_val = {{16{arg1_q[7]}}, arg1_q, arg2_q};   end
                    C_ILOAD:  begin push_en = 1'b1; push_val = lva_rd_q;                            end
                    C_DUP:    if (empty) err_set = 1'b1; else begin push_en = 1'b1; push_val = top_w; end
                    C_ISTORE: begin lva_we = 1'b1; lva_wdata = b_q;                                 end
                    default: ;
                endcase
            end
            DONE:    state_nx = bus.op_start ? DECODE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            opc_q   <= '0;
            arg1_q  <= '0;
            arg2_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opc_q  <= bus.op_code;
                arg1_q <= bus.arg1;
                arg2_q <= bus.arg2;
            end
            if (pop_en && state == POP_B) b_q <= top_w;
            if (pop_en && state == POP_A) a_q <= top_w;
            if (pop_en && !empty)                      depth_q <= depth_q - 7'd1;
            else if (push_en && !full)                 depth_q <= depth_q + 7'd1;
            else if (push2_en && depth_q <= FULL - 7'd2) depth_q <= depth_q + 7'd2;
            if (err_set || (pop_en && empty) || (push_en && full) ||
                (push2_en && depth_q > FULL - 7'd2))
                err_q <= 1'b1;
        end
    end

    // Storage arrays are not reset: an aborted instruction keeps any write already committed.
    always_ff @(posedge clk) begin
        if (push_en && !full) stk[SAW'(depth_q)] <= push_val;
        if (push2_en && depth_q <= FULL - 7'd2) begin
            stk[SAW'(depth_q)]         <= b_q;
            stk[SAW'(depth_q + 7'd1)]  <= a_q;
        end
        if (lva_we) lva[LAW'(lva_idx)] <= lva_wdata;
        if (lva_re) lva_rd_q <= lva[LAW'(lva_idx)];
    end

    assign bus.op_done     = (state == DONE);
    assign bus.busy        = (state != IDLE);
    assign bus.offset      = (state == DONE) ? (taken ? {arg1_q, arg2_q} : inst_len) : '0;
    assign bus.stack_top   = top_w;
    assign bus.stack_depth = depth_q;
    assign bus.error       = err_q;
endmodule

// File: tb/tb_control_lva_stack32.sv
// Bench for control_lva_stack32: queue/array reference model feeds a scoreboard that a
// monitor drains on every op_done.
module tb_control_lva_stack32;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_lva_stack32_if bus_if ();

    control_lva_stack32 #(.LVA_SIZE(256), .STACK_DEPTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] offset;
        logic [31:0] top;
        logic [6:0]  depth;
        logic        err;
        int unsigned lat;
        int unsigned cyc0;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mstk [$];
    logic [31:0] mlva [256];
    bit          merr;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mpop();
        if (mstk.size() == 0) begin
            merr = 1'b1;
            return '0;
        end
        return mstk.pop_back();
    endfunction

    function automatic void mpush(input logic [31:0] v);
        if (mstk.size() >= 64) merr = 1'b1;
        else mstk.push_back(v);
    endfunction

    task automatic model(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2, output exp_t e);
        logic [31:0] a, b, r;
        logic [15:0] tgt;
        logic        tk;
        tgt      = {a1, a2};
        e.op     = op;
        e.offset = 16'd1;
        e.lat    = 2;
        case (op) inside
            8'h00: ;
            [8'h02:8'h08]: begin mpush(32'(int'(op) - 3)); e.lat = 3; end
            8'h10: begin mpush({{24{a1[7]}}, a1}); e.lat = 3; e.offset = 2; end
            8'h11: begin mpush({{16{a1[7]}}, a1, a2}); e.lat = 3; e.offset = 3; end
            8'h15: begin mpush(mlva[a1]); e.lat = 4; e.offset = 2; end
            [8'h1A:8'h1D]: begin mpush(mlva[op - 8'h1A]); e.lat = 4; end
            8'h36: begin mlva[a1] = mpop(); e.lat = 4; e.offset = 2; end
            [8'h3B:8'h3E]: begin mlva[op - 8'h3B] = mpop(); e.lat = 4; end
            8'h57: begin void'(mpop()); e.lat = 3; end
            8'h59: begin mpush(mstk[$]); e.lat = 3; end
            8'h5F: begin b = mpop(); a = mpop(); mpush(b); mpush(a); e.lat = 5; end
            8'h60, 8'h64, 8'h68, 8'h7E, 8'h80, 8'h82: begin
                b = mpop();
                a = mpop();
                case (op)
                    8'h60:   r = a + b;
                    8'h64:   r = a - b;
                    8'h68:   r = a * b;
                    8'h7E:   r = a & b;
                    8'h80:   r = a | b;
                    default: r = a ^ b;
                endcase
                mpush(r);
                e.lat = 5;
            end
            8'h74: begin b = mpop(); mpush(32'd0 - b); e.lat = 4; end
            8'h84: begin mlva[a1] = mlva[a1] + {{24{a2[7]}}, a2}; e.lat = 4; e.offset = 3; end
            8'h99, 8'h9A: begin
                b  = mpop();
                tk = (op == 8'h99) ? (b == 0) : (b != 0);
                e.offset = tk ? tgt : 16'd3;
                e.lat    = 3;
            end
            [8'h9F:8'hA2]: begin
                b = mpop();
                a = mpop();
                case (op)
                    8'h9F:   tk = (a == b);
                    8'hA0:   tk = (a != b);
                    8'hA1:   tk = ($signed(a) < $signed(b));
                    default: tk = ($signed(a) >= $signed(b));
                endcase
                e.offset = tk ? tgt : 16'd3;
                e.lat    = 4;
            end
            8'hA7: e.offset = tgt;
            default: merr = 1'b1;
        endcase
        e.top   = (mstk.size() == 0) ? 32'd0 : mstk[$];
        e.depth = 7'(mstk.size());
        e.err   = merr;
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        exp_t e;
        bit   got;
        model(op, a1, a2, e);
        e.cyc0 = cyc;
        sb.push_back(e);
        bus_if.op_code  = op;
        bus_if.arg1     = a1;
        bus_if.arg2     = a2;
        bus_if.op_start = 1'b1;
        @(negedge clk);
        bus_if.op_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.op_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout op=%02h: got no op_done expected op_done within 40 cycles", op);
            void'(sb.pop_back());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_if.op_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got op_done expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("offset op=%02h", e.op), 32'(bus_if.offset), 32'(e.offset));
                chk($sformatf("top op=%02h", e.op), bus_if.stack_top, e.top);
                chk($sformatf("depth op=%02h", e.op), 32'(bus_if.stack_depth), 32'(e.depth));
                chk($sformatf("error op=%02h", e.op), 32'(bus_if.error), 32'(e.err));
                chk($sformatf("latency op=%02h", e.op), cyc - e.cyc0, e.lat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_checks(input string tag);
        chk({tag, "_offset"}, 32'(bus_if.offset), 32'd0);
        chk({tag, "_op_done"}, 32'(bus_if.op_done), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_depth"}, 32'(bus_if.stack_depth), 32'd0);
        chk({tag, "_top"}, bus_if.stack_top, 32'd0);
        chk({tag, "_error"}, 32'(bus_if.error), 32'd0);
    endtask

    initial begin
        logic [7:0] binops [6];
        logic [7:0] illops [4];
        binops = '{8'h60, 8'h64, 8'h68, 8'h7E, 8'h80, 8'h82};
        illops = '{8'h01, 8'h09, 8'hC8, 8'hFE};
        bus_if.op_start = 1'b0;
        bus_if.op_code  = '0;
        bus_if.arg1     = '0;
        bus_if.arg2     = '0;
        merr = 1'b0;
        repeat (3) @(negedge clk);
        idle_checks("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h05, 0, 0); issue(8'h06, 0, 0); issue(8'h60, 0, 0);
        issue(8'h57, 0, 0);
        issue(8'h10, 8'hFF, 0); issue(8'h36, 8'd7, 0); issue(8'h15, 8'd7, 0);
        issue(8'h84, 8'd7, 8'h05); issue(8'h15, 8'd7, 0);
        issue(8'h11, 8'h7F, 8'hFF); issue(8'h59, 0, 0); issue(8'h68, 0, 0);
        issue(8'h02, 0, 0); issue(8'h5F, 0, 0); issue(8'h64, 0, 0);
        while (mstk.size() > 0) issue(8'h57, 0, 0);
        issue(8'h04, 0, 0); issue(8'h05, 0, 0); issue(8'hA1, 8'hFF, 8'hF0);
        issue(8'h03, 0, 0); issue(8'h9A, 8'h00, 8'h08);
        issue(8'hA7, 8'h00, 8'h20);
        issue(8'h57, 0, 0);
        while (mstk.size() < 64) issue(8'h04, 0, 0);
        issue(8'h10, 8'h33, 0);
        issue(8'hFE, 0, 0);

        // Abort an imul in its EXEC cycle.
        while (mstk.size() > 0) issue(8'h57, 0, 0);
        issue(8'h05, 0, 0); issue(8'h06, 0, 0);
        bus_if.op_code  = 8'h68;
        bus_if.op_start = 1'b1;
        @(negedge clk);
        bus_if.op_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        mstk.delete();
        merr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        idle_checks("abort");

        for (int i = 0; i < 8; i++) begin
            issue(8'h10, 8'($urandom), 0);
            issue(8'h36, 8'(i), 0);
        end
        for (int n = 0; n < 250; n++) begin
            int unsigned r;
            logic [7:0] ix;
            r  = $urandom_range(0, 19);
            ix = 8'($urandom_range(0, 7));
            case (r)
                0:  issue(8'h00, 0, 0);
                1:  issue(8'($urandom_range(2, 8)), 0, 0);
                2, 18: issue(8'h10, 8'($urandom), 0);
                3, 19: issue(8'h11, 8'($urandom), 8'($urandom));
                4:  issue(8'h15, ix, 0);
                5:  issue(8'($urandom_range(8'h1A, 8'h1D)), 0, 0);
                6:  issue(8'h36, ix, 0);
                7:  issue(8'($urandom_range(8'h3B, 8'h3E)), 0, 0);
                8:  issue(8'h57, 0, 0);
                9:  if (mstk.size() > 0) issue(8'h59, 0, 0); else issue(8'h07, 0, 0);
                10: issue(8'h5F, 0, 0);
                11: issue(binops[$urandom_range(0, 5)], 0, 0);
                12: issue(8'h74, 0, 0);
                13: issue(8'h84, ix, 8'($urandom));
                14: issue(8'($urandom_range(8'h99, 8'h9A)), 8'($urandom), 8'($urandom));
                15: issue(8'($urandom_range(8'h9F, 8'hA2)), 8'($urandom), 8'($urandom));
                16: issue(8'hA7, 8'($urandom), 8'($urandom));
                default: issue(illops[$urandom_range(0, 3)], 0, 0);
            endcase
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
